irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Memory-mapped interrupt controller directly upstream of the CPU irq input (today driven by ps2 key_irq alone).
//  Collects up to NSRC sources (ps2, uart rx_new, spi_ready, freqgen, ...) and latches them as pending.
//  Masks them and drives one registered irq line to the CPU.
//  The CPU reads the highest-priority pending id and acknowledges it through the top-level I/O address decoder.
// PARAMETERS
//  NSRC         8   number of interrupt sources, 1..15 (bit 15 of MASK is the global enable)
//  SYNC_STAGES  2   synchronizer flops per source, 0 = sources already in the cpu_clk domain
// PORTS
//  cpu_clk    in   1     CPU clock; all state is on posedge
//  rst_in     in   1     asynchronous reset, active-low
//  src        in   NSRC  raw interrupt request lines, active-high
//  reg_addr   in   2     register offset: 0 PEND, 1 MASK, 2 VECTOR, 3 EDGE
//  wr_data    in   16    CPU write data (ram_in)
//  wr         in   1     write strobe, gated by the decoder to this block's address range
//  read_done  in   1     one-cycle pulse at the end of a CPU read of this block
//  rd_data    out  16    read data, combinational from reg_addr
//  irq        out  1     registered interrupt request to the CPU
// BEHAVIOUR
//  Reset (rst_in low, async): pending=0, mask=0, gie=0, edge_cfg=0, sync/prev flops=0, irq=0.
//  Reset release returns the block to this idle state; a reset mid-operation discards all pending requests.
//  Source path: src[i] -> SYNC_STAGES flops -> s[i].
//   - Edge mode (edge_cfg[i]=1): rise = s[i] & ~prev[i]; prev[i] <= s[i] every cycle.
//   - Level mode (edge_cfg[i]=0): pending[i] follows s[i] each cycle; W1C has no effect while s[i]=1.
//  Edge pending update each cycle: pending[i] <= rise[i] | (pending[i] & ~clr[i]).
//   - Set wins over a same-cycle clear or ack.
//  clr[i] = (wr & reg_addr==0 & wr_data[i]) | (ack & id==i).
//  MASK (addr 1) is R/W.
//   - bits[NSRC-1:0] hold mask[i] (1 = enabled); bit 15 holds gie.
//   - Other bits read 0.
//  EDGE (addr 3) is R/W: bits[NSRC-1:0] hold edge_cfg; other bits read 0.
//   - Changing edge_cfg[i] does not clear pending[i].
//  PEND (addr 0): read returns {0, pending}; a write clears the bits written as 1 (W1C).
//  active = pending & mask.
//   - id = lowest index set in active (index 0 is the highest priority).
//   - any = |active.
//  VECTOR (addr 2): read returns {any, 11'b0, id[3:0]}; id=0 when any=0.
//   - Writes to VECTOR are ignored.
//  ack = read_done & reg_addr==2 & any.
//   - Clears pending[id] on the same edge for edge-mode sources only.
//   - read_done on other addresses has no effect.
//  irq <= gie & any, registered: one cycle after pending/mask changes.
//  Latency with SYNC_STAGES=S: edge-mode src rising before edge E0 -> pending at edge E(S), irq high after edge E(S+1).
//  Wrap/width rules:
//   - wr_data bits above NSRC are ignored except MASK bit 15.
//   - Sources that are held or chatter set pending at most once per rising edge; no counting.
//  A multi-cycle wr strobe is allowed and is idempotent for every register.
// STRUCTURE
//  irq_defs.vh holds shared constants: IRQ_REG_PEND=0, IRQ_REG_MASK=1, IRQ_REG_VECTOR=2, IRQ_REG_EDGE=3, IRQ_GIE_BIT=15.
//   - It also holds the fixed source-index assignment used by top (0 ps2, 1 uart rx, 2 spi, 3 freqgen).
//  Sub-module irq_sync_edge: one per source via generate.
//   - Parameter SYNC_STAGES; ports cpu_clk, rst_in, in; outputs level and rise.
//  irq_ctrl itself holds the register file, the priority encoder (a for-loop from high to low index) and the irq flop.
// TESTING
//  1. Reset: drive rst_in=0 mid-traffic -> irq=0 immediately; then PEND/MASK/EDGE read 0x0000 and VECTOR reads 0x0000.
//  2. Edge and latency: EDGE=0x00FF, MASK=0x8004, pulse src[2] one cycle (S=2).
//     - irq rises exactly 4 edges later; VECTOR reads 0x8002.
//     - read_done on VECTOR -> PEND=0x0000, irq low next cycle.
//  3. Priority: EDGE=0x00FF, MASK=0x80FF; pulse src[5] and src[1] in the same cycle.
//     - VECTOR=0x8001; after ack, VECTOR=0x8005; after a second ack, VECTOR=0x0000.
//  4. Level mode: EDGE=0, MASK=0x8001, hold src[0]=1 -> writing PEND=0x0001 does not clear it.
//     - Drop src[0] -> PEND=0x0000 after S+1 cycles and irq low one cycle later.
//  5. Set/clear collision: edge-mode src[3] rises on the same edge as W1C PEND=0x0008 -> pending[3] stays 1.
//  6. Masking: pend[4] set, MASK=0x0010 with gie=0 -> irq stays 0; set MASK=0x8010 -> irq=1 one cycle later.
//     - MASK=0x8000 -> irq=0 and VECTOR=0x0000 while PEND still reads 0x0010.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, the global
// enable bit position and the fixed board source-index assignment.
package irq_ctrl_pkg;

   localparam logic [1:0] IRQ_REG_PEND   = 2'd0;
   localparam logic [1:0] IRQ_REG_MASK   = 2'd1;
   localparam logic [1:0] IRQ_REG_VECTOR = 2'd2;
   localparam logic [1:0] IRQ_REG_EDGE   = 2'd3;

   localparam int IRQ_GIE_BIT = 15;

   // Source wiring at the top level; lower index means higher priority.
   localparam int IRQ_SRC_PS2     = 0;
   localparam int IRQ_SRC_UART_RX = 1;
   localparam int IRQ_SRC_SPI     = 2;
   localparam int IRQ_SRC_FREQGEN = 3;

   function automatic logic [15:0] vector_word(input logic any, input logic [3:0] id);
      return {any, 11'b0, id};
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-source synchronizer with a rising-edge detector on the synchronized level.
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic cpu_clk,
   input  logic rst_in,
   input  logic in,
   output logic level,
   output logic rise
);

   logic prev;

   generate
      if (SYNC_STAGES == 0) begin : g_bypass
         assign level = in;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync;

         always_ff @(posedge cpu_clk or negedge rst_in) begin
            if (!rst_in) begin
               sync <= '0;
            end else begin
               sync[0] <= in;
               for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
            end
         end

         assign level = sync[SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge cpu_clk or negedge rst_in) begin
      if (!rst_in) prev <= 1'b0;
      else         prev <= level;
   end

   assign rise = level & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: latches per-source requests, masks them,
// reports the highest-priority pending id and drives a registered irq line.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NSRC        = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic            cpu_clk,
   input  logic            rst_in,
   input  logic [NSRC-1:0] src,
   input  logic [1:0]      reg_addr,
   input  logic [15:0]     wr_data,
   input  logic            wr,
   input  logic            read_done,
   output logic [15:0]     rd_data,
   output logic            irq
);

   logic [NSRC-1:0] level;
   logic [NSRC-1:0] rise;
   logic [NSRC-1:0] pending;
   logic [NSRC-1:0] mask;
   logic [NSRC-1:0] edge_cfg;
   logic [NSRC-1:0] active;
   logic [NSRC-1:0] clr;
   logic            gie;
   logic            any;
   logic            ack;
   logic            wr_pend;
   logic [3:0]      id;
   logic            unused_wr_bits;

   genvar g;
   generate
      for (g = 0; g < NSRC; g++) begin : g_src
         irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
         ) u_sync (
            .cpu_clk(cpu_clk),
            .rst_in (rst_in),
            .in     (src[g]),
            .level  (level[g]),
            .rise   (rise[g])
         );
      end
   endgenerate

   assign active = pending & mask;
   assign any    = |active;

   // Scan from high to low so the lowest active index is the last one written.
   always_comb begin
      id = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (active[i]) id = 4'(i);
      end
   end

   assign ack     = read_done && (reg_addr == IRQ_REG_VECTOR) && any;
   assign wr_pend = wr && (reg_addr == IRQ_REG_PEND);

   always_comb begin
      clr = '0;
      for (int i = 0; i < NSRC; i++) begin
         clr[i] = (wr_pend && wr_data[i]) || (ack && (id == 4'(i)));
      end
   end

   // Edge sources latch and hold until cleared, with a new edge beating a clear;
   // level sources simply mirror the synchronized line.
   always_ff @(posedge cpu_clk or negedge rst_in) begin
      if (!rst_in) begin
         pending <= '0;
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (edge_cfg[i]) pending[i] <= rise[i] | (pending[i] & ~clr[i]);
            else             pending[i] <= level[i];
         end
      end
   end

   always_ff @(posedge cpu_clk or negedge rst_in) begin
      if (!rst_in) begin
         mask     <= '0;
         gie      <= 1'b0;
         edge_cfg <= '0;
      end else if (wr) begin
         if (reg_addr == IRQ_REG_MASK) begin
            mask <= wr_data[NSRC-1:0];
            gie  <= wr_data[IRQ_GIE_BIT];
         end
         if (reg_addr == IRQ_REG_EDGE) edge_cfg <= wr_data[NSRC-1:0];
      end
   end

   always_ff @(posedge cpu_clk or negedge rst_in) begin
      if (!rst_in) irq <= 1'b0;
      else         irq <= gie & any;
   end

   always_comb begin
      rd_data = '0;
      case (reg_addr)
         IRQ_REG_PEND: rd_data[NSRC-1:0] = pending;
         IRQ_REG_MASK: begin
            rd_data[NSRC-1:0]   = mask;
            rd_data[IRQ_GIE_BIT] = gie;
         end
         IRQ_REG_VECTOR: rd_data = vector_word(any, id);
         IRQ_REG_EDGE:   rd_data[NSRC-1:0] = edge_cfg;
         default:        rd_data = '0;
      endcase
   end

   assign unused_wr_bits = &{1'b0, wr_data};

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: NSRC=8, SYNC_STAGES=2; inputs driven and outputs
// sampled on the falling edge.
module tb_irq_ctrl;

   localparam int NSRC = 8;
   localparam int S    = 2;

   logic            cpu_clk = 1'b0;
   logic            rst_in;
   logic [NSRC-1:0] src;
   logic [1:0]      reg_addr;
   logic [15:0]     wr_data;
   logic            wr;
   logic            read_done;
   logic [15:0]     rd_data;
   logic            irq;

   int checks   = 0;
   int failures = 0;

   irq_ctrl #(.NSRC(NSRC), .SYNC_STAGES(S)) dut (
      .cpu_clk  (cpu_clk),
      .rst_in   (rst_in),
      .src      (src),
      .reg_addr (reg_addr),
      .wr_data  (wr_data),
      .wr       (wr),
      .read_done(read_done),
      .rd_data  (rd_data),
      .irq      (irq)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge cpu_clk);
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
      reg_addr = a; wr_data = d; wr = 1'b1;
      @(negedge cpu_clk);
      wr = 1'b0; wr_data = '0;
   endtask

   task automatic rd_reg(input logic [1:0] a, output logic [15:0] d);
      reg_addr = a;
      #1 d = rd_data;
   endtask

   task automatic ack_vec();
      reg_addr = 2'd2; read_done = 1'b1;
      @(negedge cpu_clk);
      read_done = 1'b0;
   endtask

   task automatic pulse_src(input logic [NSRC-1:0] p);
      src = p;
      @(negedge cpu_clk);
      src = '0;
   endtask

   task automatic test_reset();
      logic [15:0] v;
      rst_in = 1'b0;
      cyc(2);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", irq); end
      rst_in = 1'b1;
      cyc(1);
      for (int a = 0; a < 4; a++) begin
         rd_reg(2'(a), v);
         checks++;
         if (v !== 16'h0000) begin failures++; $display("FAIL reset_reg%0d: got %h expected 0000", a, v); end
      end
   endtask

   task automatic test_regs();
      logic [15:0] v;
      wr_reg(2'd1, 16'hFFFF);
      rd_reg(2'd1, v);
      checks++; if (v !== 16'h80FF) begin failures++; $display("FAIL mask_width: got %h expected 80ff", v); end
      wr_reg(2'd3, 16'hFFFF);
      rd_reg(2'd3, v);
      checks++; if (v !== 16'h00FF) begin failures++; $display("FAIL edge_width: got %h expected 00ff", v); end
      wr_reg(2'd2, 16'hFFFF);
      rd_reg(2'd2, v);
      checks++; if (v !== 16'h0000) begin failures++; $display("FAIL vector_wr_ignored: got %h expected 0000", v); end
      wr_reg(2'd1, 16'h0000);
   endtask

   task automatic test_edge_latency();
      logic [15:0] v;
      wr_reg(2'd3, 16'h00FF);
      wr_reg(2'd1, 16'h8004);
      pulse_src(8'h04);
      cyc(2);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL latency_early: got %b expected 0", irq); end
      rd_reg(2'd0, v);
      checks++; if (v !== 16'h0004) begin failures++; $display("FAIL latency_pend: got %h expected 0004", v); end
      cyc(1);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL latency_irq: got %b expected 1", irq); end
      rd_reg(2'd2, v);
      checks++; if (v !== 16'h8002) begin failures++; $display("FAIL latency_vector: got %h expected 8002", v); end
      ack_vec();
      rd_reg(2'd0, v);
      checks++; if (v !== 16'h0000) begin failures++; $display("FAIL ack_pend: got %h expected 0000", v); end
      cyc(1);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ack_irq: got %b expected 0", irq); end
   endtask

   task automatic test_priority();
      logic [15:0] v;
      wr_reg(2'd1, 16'h80FF);
      pulse_src(8'h22);
      cyc(3);
      rd_reg(2'd2, v);
      checks++; if (v !== 16'h8001) begin failures++; $display("FAIL prio_first: got %h expected 8001", v); end
      ack_vec();
      rd_reg(2'd2, v);
      checks++; if (v !== 16'h8005) begin failures++; $display("FAIL prio_second: got %h expected 8005", v); end
      ack_vec();
      rd_reg(2'd2, v);
      checks++; if (v !== 16'h0000) begin failures++; $display("FAIL prio_empty: got %h expected 0000", v); end
      cyc(1);
   endtask

   task automatic test_level();
      logic [15:0] v;
      wr_reg(2'd3, 16'h0000);
      wr_reg(2'd1, 16'h8001);
      src = 8'h01;
      cyc(4);
      wr_reg(2'd0, 16'h0001);
      rd_reg(2'd0, v);
      checks++; if (v !== 16'h0001) begin failures++; $display("FAIL level_w1c: got %h expected 0001", v); end
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL level_irq: got %b expected 1", irq); end
      src = 8'h00;
      cyc(S + 1);
      rd_reg(2'd0, v);
      checks++; if (v !== 16'h0000) begin failures++; $display("FAIL level_drop_pend: got %h expected 0000", v); end
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL level_drop_irq_hold: got %b expected 1", irq); end
      cyc(1);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL level_drop_irq: got %b expected 0", irq); end
   endtask

   task automatic test_collision();
      logic [15:0] v;
      wr_reg(2'd1, 16'h0000);
      wr_reg(2'd3, 16'h00FF);
      src = 8'h08;
      cyc(1);
      src = 8'h00;
      cyc(1);
      // rise on s[3] is now visible; the W1C lands on the same edge that sets it
      wr_reg(2'd0, 16'h0008);
      rd_reg(2'd0, v);
      checks++; if (v !== 16'h0008) begin failures++; $display("FAIL collision_set_wins: got %h expected 0008", v); end
      wr_reg(2'd0, 16'h0008);
      rd_reg(2'd0, v);
      checks++; if (v !== 16'h0000) begin failures++; $display("FAIL w1c_clear: got %h expected 0000", v); end
   endtask

   task automatic test_masking();
      logic [15:0] v;
      pulse_src(8'h10);
      cyc(3);
      wr_reg(2'd1, 16'h0010);
      cyc(2);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL gie_off_irq: got %b expected 0", irq); end
      wr_reg(2'd1, 16'h8010);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL gie_on_irq_early: got %b expected 0", irq); end
      cyc(1);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL gie_on_irq: got %b expected 1", irq); end
      wr_reg(2'd1, 16'h8000);
      rd_reg(2'd2, v);
      checks++; if (v !== 16'h0000) begin failures++; $display("FAIL masked_vector: got %h expected 0000", v); end
      cyc(1);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL masked_irq: got %b expected 0", irq); end
      rd_reg(2'd0, v);
      checks++; if (v !== 16'h0010) begin failures++; $display("FAIL masked_pend: got %h expected 0010", v); end
   endtask

   task automatic test_reset_mid_traffic();
      logic [15:0] v;
      wr_reg(2'd1, 16'h8010);
      cyc(1);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL midreset_pre_irq: got %b expected 1", irq); end
      #2 rst_in = 1'b0;
      #1;
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL midreset_irq: got %b expected 0", irq); end
      cyc(1);
      rst_in = 1'b1;
      cyc(1);
      for (int a = 0; a < 4; a++) begin
         rd_reg(2'(a), v);
         checks++;
         if (v !== 16'h0000) begin failures++; $display("FAIL midreset_reg%0d: got %h expected 0000", a, v); end
      end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL midreset_irq_after: got %b expected 0", irq); end
   endtask

   initial begin
      src = '0; reg_addr = '0; wr_data = '0; wr = 1'b0; read_done = 1'b0;
      @(negedge cpu_clk);
      test_reset();
      test_regs();
      test_edge_latency();
      test_priority();
      test_level();
      test_collision();
      test_masking();
      test_reset_mid_traffic();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
